sha256_block_feeder: RTL and testbench

- Downstream consumer of the DMA engine's read FIFO. Pops 32-bit message words from the FIFO and applies SHA-256 message padding (single 1 bit, zero fill, 64-bit big-endian bit length).
- Presents the padded message to the SHA-256 core as a serial stream: 16 words per 512-bit block.
- Tracks block boundaries and the final block, and waits for the core's ready signal before starting each block.

---
 rtl/sha256_block_feeder_if.sv | 36 +++
 rtl/sha256_block_feeder.sv | 183 ++++++++++++++++++
 tb/tb_sha256_block_feeder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_block_feeder_if.sv
// Purpose: bundles the feeder's DMA control, FIFO read port, SHA-256 word stream and status lines.
// Latency: none, wires only.
// Backpressure: FIFO side stalls on fifo_rd_empty_i; core side gates each block start on sha256_rdy_i.
// Ports: master = feeder (drives fifo_rd_en_o, sha256_*_o, busy_o, done_pulse_o, dbg_state_o);
//        slave  = environment (DMA controller, read FIFO, SHA-256 core).
interface sha256_block_feeder_if;
   logic        dma_enable_i;
   logic [25:0] dma_bit_len_i;
   logic        dma_start_i;
   logic        fifo_rd_en_o;
   logic [31:0] fifo_rd_dout_i;
   logic        fifo_rd_empty_i;
   logic        sha256_rdy_i;
   logic [31:0] sha256_word_o;
   logic        sha256_word_valid_o;
   logic [3:0]  sha256_word_idx_o;
   logic        sha256_block_done_o;
   logic        sha256_last_o;
   logic        busy_o;
   logic        done_pulse_o;
   logic [3:0]  dbg_state_o;

   modport master (
      input  dma_enable_i, dma_bit_len_i, dma_start_i,
      input  fifo_rd_dout_i, fifo_rd_empty_i, sha256_rdy_i,
      output fifo_rd_en_o, sha256_word_o, sha256_word_valid_o, sha256_word_idx_o,
      output sha256_block_done_o, sha256_last_o, busy_o, done_pulse_o, dbg_state_o
   );

   modport slave (
      output dma_enable_i, dma_bit_len_i, dma_start_i,
      output fifo_rd_dout_i, fifo_rd_empty_i, sha256_rdy_i,
      input  fifo_rd_en_o, sha256_word_o, sha256_word_valid_o, sha256_word_idx_o,
      input  sha256_block_done_o, sha256_last_o, busy_o, done_pulse_o, dbg_state_o
   );
endinterface

// File: rtl/sha256_block_feeder.sv
// Purpose: pops message words from the DMA read FIFO, applies SHA-256 padding, streams 16-word blocks.
// Latency: FIFO word 4 cycles (NEXT/POP/LOAD/EMIT), padding word 2 cycles (NEXT/EMIT), +WAIT_RDY per block.
// Backpressure: stalls in POP while the FIFO is empty; each block waits for sha256_rdy_i.
// Ports: clk_i, rstn_i (async active-low) plus bus (sha256_block_feeder_if.master).
// Option: define FEEDER_BYTE_SWAP_EN to byte-reverse FIFO words (little-endian images) before padding.
module sha256_block_feeder #(
   parameter int unsigned FIFO_LAT = 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   sha256_block_feeder_if.master bus
);

   // LOAD captures FIFO data exactly one cycle after the pop strobe.
   if (FIFO_LAT != 1) begin : g_lat_chk
      $error("sha256_block_feeder: only FIFO_LAT = 1 is supported");
   end

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WAIT_RDY = 4'd1,
      ST_NEXT     = 4'd2,
      ST_POP      = 4'd3,
      ST_LOAD     = 4'd4,
      ST_EMIT     = 4'd5,
      ST_BLK_END  = 4'd6,
      ST_GAP      = 4'd7,
      ST_DONE     = 4'd8
   } state_t;

   state_t      state_q, state_d;
   logic [25:0] len_q, len_d;       // message length L in bits
   logic [20:0] dcnt_q, dcnt_d;     // D: number of full data words
   logic [4:0]  rem_q, rem_d;       // r: bits in the partial data word
   // k spans 0..16N-1; for L near 2^26, 16N reaches 2097168, one bit beyond 21.
   logic [21:0] ktot_q, ktot_d;     // 16N
   logic [21:0] k_q, k_d;           // global word index
   logic [31:0] word_q, word_d;
   logic        start_q;

   logic        start_rise, need_fifo, tail_word;
   logic [17:0] nblk;
   logic [31:0] raw_word, fifo_word, pad_word;
   logic        rd_en, word_vld, blk_done, last_blk, done_pls;

   assign start_rise = bus.dma_start_i & ~start_q;
   assign nblk       = 18'(({1'b0, bus.dma_bit_len_i} + 27'd64) >> 9) + 18'd1;
   // Word D carries the leftover r message bits when L is not word aligned.
   assign tail_word  = (k_q == {1'b0, dcnt_q}) && (rem_q != 5'd0);
   assign need_fifo  = (k_q < {1'b0, dcnt_q}) || tail_word;

`ifdef FEEDER_BYTE_SWAP_EN
   assign raw_word = {bus.fifo_rd_dout_i[7:0],   bus.fifo_rd_dout_i[15:8],
                      bus.fifo_rd_dout_i[23:16], bus.fifo_rd_dout_i[31:24]};
`else
   assign raw_word = bus.fifo_rd_dout_i;
`endif

   // Partial word: keep the top r message bits, then append the single 1 bit.
   assign fifo_word = tail_word ? ((raw_word & ~(32'hFFFF_FFFF >> rem_q)) | (32'h8000_0000 >> rem_q))
                                : raw_word;

   always_comb begin
      pad_word = 32'h0000_0000;
      if (k_q == {1'b0, dcnt_q}) begin
         pad_word = 32'h8000_0000;
      end else if (k_q == ktot_q - 22'd1) begin
         pad_word = {6'b0, len_q};
      end
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      dcnt_d   = dcnt_q;
      rem_d    = rem_q;
      ktot_d   = ktot_q;
      k_d      = k_q;
      word_d   = word_q;
      rd_en    = 1'b0;
      word_vld = 1'b0;
      blk_done = 1'b0;
      last_blk = 1'b0;
      done_pls = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_rise && bus.dma_enable_i) begin
               len_d   = bus.dma_bit_len_i;
               dcnt_d  = bus.dma_bit_len_i[25:5];
               rem_d   = bus.dma_bit_len_i[4:0];
               ktot_d  = {nblk, 4'b0000};
               k_d     = '0;
               state_d = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            if (bus.sha256_rdy_i) state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (need_fifo) begin
               state_d = ST_POP;
            end else begin
               word_d  = pad_word;
               state_d = ST_EMIT;
            end
         end
         ST_POP: begin
            if (!bus.fifo_rd_empty_i) begin
               rd_en   = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            word_d  = fifo_word;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            word_vld = 1'b1;
            k_d      = k_q + 22'd1;
            state_d  = (k_q[3:0] == 4'd15) ? ST_BLK_END : ST_NEXT;
         end
         ST_BLK_END: begin
            // k has already advanced past word 15 of this block.
            blk_done = 1'b1;
            last_blk = (k_q == ktot_q);
            state_d  = last_blk ? ST_DONE : ST_GAP;
         end
         ST_GAP: begin
            state_d = ST_WAIT_RDY;
         end
         ST_DONE: begin
            done_pls = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort: drop everything, suppress any strobe of this cycle.
      if ((state_q != ST_IDLE) && !bus.dma_enable_i) begin
         state_d  = ST_IDLE;
         rd_en    = 1'b0;
         word_vld = 1'b0;
         blk_done = 1'b0;
         last_blk = 1'b0;
         done_pls = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         dcnt_q  <= '0;
         rem_q   <= '0;
         ktot_q  <= '0;
         k_q     <= '0;
         word_q  <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         dcnt_q  <= dcnt_d;
         rem_q   <= rem_d;
         ktot_q  <= ktot_d;
         k_q     <= k_d;
         word_q  <= word_d;
         start_q <= bus.dma_start_i;
      end
   end

   assign bus.fifo_rd_en_o        = rd_en;
   assign bus.sha256_word_valid_o = word_vld;
   assign bus.sha256_word_o       = word_vld ? word_q : 32'h0;
   assign bus.sha256_word_idx_o   = word_vld ? k_q[3:0] : 4'h0;
   assign bus.sha256_block_done_o = blk_done;
   assign bus.sha256_last_o       = last_blk;
   assign bus.done_pulse_o        = done_pls;
   assign bus.busy_o              = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign bus.dbg_state_o         = state_q;

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Purpose: directed checks of sha256_block_feeder padding, block sequencing, FIFO stall and abort.
// Latency: stimulus driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: FIFO empty and core ready are modelled from the falling-edge monitor.
module tb_sha256_block_feeder;

   logic clk;
   logic rstn;

   sha256_block_feeder_if bus();

   sha256_block_feeder #(.FIFO_LAT(1)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #4 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // FIFO model: one-cycle read latency.
   logic [31:0] fifo_q[$];
   logic [31:0] dout_r = 32'h0;
   int          pop_cnt = 0;
   assign bus.fifo_rd_dout_i = dout_r;

   initial begin
      forever begin
         @(posedge clk);
         if (bus.fifo_rd_en_o) begin
            pop_cnt++;
            if (fifo_q.size() > 0) dout_r <= fifo_q.pop_front();
            else                   dout_r <= 32'hDEAD_BEEF;
         end
      end
   end

   // Controls owned by the main thread.
   int   clr_seq   = 0;
   int   gap_hold  = 0;
   logic stall_arm = 1'b0;
   logic abort_arm = 1'b0;

   // State owned by the monitor.
   logic [31:0] got_w[$];
   logic [3:0]  got_idx[$];
   logic        got_last[$];
   int   seen_seq = 0;
   int   done_cnt = 0;
   int   stall_left = 0, stall_bad = 0, stall_pop_cyc = 0;
   int   rdy_low = 0, rdy_bad = 0, wait_cyc = 0;
   logic stall_fired = 1'b0, abort_hit = 1'b0;

   initial begin
      bus.dma_enable_i    = 1'b1;
      bus.fifo_rd_empty_i = 1'b1;
      bus.sha256_rdy_i    = 1'b1;
      forever begin
         @(negedge clk);
         if (clr_seq != seen_seq) begin
            seen_seq = clr_seq;
            got_w.delete(); got_idx.delete(); got_last.delete();
            done_cnt = 0; stall_bad = 0; stall_pop_cyc = 0; rdy_bad = 0; wait_cyc = 0;
         end
         if (stall_left > 0) begin
            if (bus.fifo_rd_en_o || bus.sha256_word_valid_o) stall_bad++;
            if (bus.dbg_state_o == 4'd3) stall_pop_cyc++;
            stall_left--;
         end
         if (rdy_low > 0) rdy_low--;
         if (bus.sha256_word_valid_o) begin
            got_w.push_back(bus.sha256_word_o);
            got_idx.push_back(bus.sha256_word_idx_o);
            if (!bus.sha256_rdy_i) rdy_bad++;
            if (stall_arm && !stall_fired && bus.sha256_word_idx_o == 4'd4) begin
               stall_fired = 1'b1;
               stall_left  = 20;
            end
            if (abort_arm && !abort_hit && bus.sha256_word_idx_o == 4'd7) abort_hit = 1'b1;
         end
         if (!stall_arm) stall_fired = 1'b0;
         if (!abort_arm) abort_hit = 1'b0;
         if (bus.dbg_state_o == 4'd1) wait_cyc++;
         if (bus.sha256_block_done_o) begin
            got_last.push_back(bus.sha256_last_o);
            rdy_low = gap_hold;
         end
         if (bus.done_pulse_o) done_cnt++;
         bus.fifo_rd_empty_i = (fifo_q.size() == 0) || (stall_left > 0);
         bus.sha256_rdy_i    = (rdy_low == 0);
         bus.dma_enable_i    = !abort_hit;
      end
   end

   logic [31:0] exp_w[$];
   int          pop_base;

   task automatic clear_cap();
      clr_seq++;
      exp_w.delete();
      repeat (2) @(negedge clk);
      pop_base = pop_cnt;
   endtask

   task automatic exp_add(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) exp_w.push_back(w);
   endtask

   task automatic start_msg(input logic [25:0] len);
      bus.dma_bit_len_i = len;
      bus.dma_start_i   = 1'b1;
      @(negedge clk);
      bus.dma_start_i   = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int c = 0;
      while (done_cnt == 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      chk({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_nwords"}, got_w.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         chk($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
         chk($sformatf("%s_idx%0d", tag, i), got_idx[i], i % 16);
      end
   endtask

   task automatic cmp_last(input string tag, input int n, input logic [1:0] bits);
      chk({tag, "_nblk"}, got_last.size(), n);
      for (int i = 0; i < n && i < got_last.size(); i++)
         chk($sformatf("%s_last%0d", tag, i), got_last[i], bits[i]);
   endtask

   initial begin
      rstn              = 1'b0;
      bus.dma_start_i   = 1'b0;
      bus.dma_bit_len_i = '0;
      repeat (3) @(negedge clk);

      chk("rst_state", bus.dbg_state_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_rd_en", bus.fifo_rd_en_o, 0);
      chk("rst_valid", bus.sha256_word_valid_o, 0);
      chk("rst_word", bus.sha256_word_o, 0);
      chk("rst_idx", bus.sha256_word_idx_o, 0);
      chk("rst_blk_done", bus.sha256_block_done_o, 0);
      chk("rst_last", bus.sha256_last_o, 0);
      chk("rst_done", bus.done_pulse_o, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // L=24 "abc", start held high through the run and afterwards.
      clear_cap();
      fifo_q.push_back(32'h6162_63FF);
      bus.dma_bit_len_i = 26'd24;
      bus.dma_start_i   = 1'b1;
      wait_done("t24", 1000);
      repeat (4) @(negedge clk);
      chk("t24_no_restart", bus.dbg_state_o, 0);
      chk("t24_busy", bus.busy_o, 0);
      bus.dma_start_i = 1'b0;
      exp_add(32'h6162_6380, 1); exp_add(32'h0, 14); exp_add(32'h0000_0018, 1);
      cmp_stream("t24");
      cmp_last("t24", 1, 2'b01);
      chk("t24_pops", pop_cnt - pop_base, 1);

      // L=0: no FIFO traffic at all.
      clear_cap();
      start_msg(26'd0);
      wait_done("t0", 1000);
      exp_add(32'h8000_0000, 1); exp_add(32'h0, 15);
      cmp_stream("t0");
      cmp_last("t0", 1, 2'b01);
      chk("t0_pops", pop_cnt - pop_base, 0);

      // L=448: two blocks, core holds ready low after the first block.
      clear_cap();
      for (int i = 0; i < 14; i++) fifo_q.push_back(32'h1111_1111);
      gap_hold = 6;
      start_msg(26'd448);
      wait_done("t448", 2000);
      gap_hold = 0;
      exp_add(32'h1111_1111, 14); exp_add(32'h8000_0000, 1); exp_add(32'h0, 16); exp_add(32'h0000_01C0, 1);
      cmp_stream("t448");
      cmp_last("t448", 2, 2'b10);
      chk("t448_pops", pop_cnt - pop_base, 14);
      chk("t448_vld_while_not_rdy", rdy_bad, 0);
      chk("t448_waited_for_rdy", wait_cyc >= 5, 1);

      // L=512: full data block, padding in a second block.
      clear_cap();
      for (int i = 0; i < 16; i++) fifo_q.push_back(32'hC0DE_0000 + 32'(i));
      start_msg(26'd512);
      wait_done("t512", 2000);
      for (int i = 0; i < 16; i++) exp_w.push_back(32'hC0DE_0000 + 32'(i));
      exp_add(32'h8000_0000, 1); exp_add(32'h0, 14); exp_add(32'h0000_0200, 1);
      cmp_stream("t512");
      cmp_last("t512", 2, 2'b10);
      chk("t512_pops", pop_cnt - pop_base, 16);

      // L=256 with the FIFO empty for 20 cycles ahead of word 5.
      clear_cap();
      for (int i = 0; i < 8; i++) fifo_q.push_back(32'hA0A0_A000 + 32'(i));
      stall_arm = 1'b1;
      start_msg(26'd256);
      wait_done("tstall", 2000);
      stall_arm = 1'b0;
      for (int i = 0; i < 8; i++) exp_w.push_back(32'hA0A0_A000 + 32'(i));
      exp_add(32'h8000_0000, 1); exp_add(32'h0, 6); exp_add(32'h0000_0100, 1);
      cmp_stream("tstall");
      chk("tstall_strobes_while_empty", stall_bad, 0);
      chk("tstall_held_in_pop", stall_pop_cyc >= 15, 1);
      chk("tstall_pops", pop_cnt - pop_base, 8);

      // L=1000 aborted at block 0 idx 7, then a fresh start.
      clear_cap();
      for (int i = 0; i < 32; i++) fifo_q.push_back(32'h0000_0100 + 32'(i));
      abort_arm = 1'b1;
      start_msg(26'd1000);
      chk("tabort_busy_running", bus.busy_o, 1);
      begin
         int c = 0;
         while (!abort_hit && c < 500) begin
            @(negedge clk);
            c++;
         end
      end
      chk("tabort_reached_idx7", abort_hit, 1);
      @(negedge clk);
      chk("tabort_state_idle", bus.dbg_state_o, 0);
      chk("tabort_busy", bus.busy_o, 0);
      repeat (10) @(negedge clk);
      chk("tabort_nwords", got_w.size(), 8);
      chk("tabort_blk_done", got_last.size(), 0);
      chk("tabort_done_pulse", done_cnt, 0);
      abort_arm = 1'b0;
      repeat (2) @(negedge clk);

      clear_cap();
      start_msg(26'd0);
      wait_done("trestart", 1000);
      exp_add(32'h8000_0000, 1); exp_add(32'h0, 15);
      cmp_stream("trestart");
      cmp_last("trestart", 1, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
